mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 133 +++++++++++++
 tb/tb_mem_access_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus between the MEM stage and memory
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data-memory access FSM, timeout abort, MEM/WB register
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               alu_MEM,
    input  logic [31:0]               rs2_mem_data_MEM,
    input  logic                      MemRead_MEM,
    input  logic                      MemWrite_MEM,
    input  logic                      RegWrite_MEM,
    input  logic                      MemtoReg_MEM,
    input  logic [4:0]                rd_MEM,
    mem_access_stage_if.master        dmem,
    output logic                      stall_MEM,
    output logic [31:0]               wb_data_WB,
    output logic [4:0]                rd_WB,
    output logic                      RegWrite_WB,
    output logic                      misaligned_MEM,
    output logic                      bus_err_MEM
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       access, aligned, is_store, tmo_hit;
    logic       misaligned, timeout, load_done;

    // Gating with rst keeps stall_MEM low while reset is held, whatever EX/MEM presents.
    assign access   = rst & (MemRead_MEM | MemWrite_MEM);
    assign aligned  = (alu_MEM[1:0] == 2'b00);
    assign is_store = MemWrite_MEM;
    // >= rather than == so a load whose handshake lands on the last cycle still aborts in WAIT.
    assign tmo_hit  = (cnt >= TMO_LAST);

    assign dmem.dmem_addr  = alu_MEM;
    assign dmem.dmem_wdata = rs2_mem_data_MEM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stall_MEM     = 1'b0;
        dmem.dmem_req = 1'b0;
        dmem.dmem_we  = 1'b0;
        misaligned    = 1'b0;
        timeout       = 1'b0;
        load_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        state_nxt = ST_REQ;
                        cnt_nxt   = 8'd0;
                        stall_MEM = 1'b1;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                dmem.dmem_req = 1'b1;
                dmem.dmem_we  = is_store;
                if (dmem.dmem_ready) begin
                    if (is_store) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT;
                        stall_MEM = 1'b1;
                        cnt_nxt   = cnt + 8'd1;
                    end
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_MEM = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    load_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_MEM = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MEM/WB register: advance when not stalled, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_WB     <= 32'd0;
            rd_WB          <= 5'd0;
            RegWrite_WB    <= 1'b0;
            misaligned_MEM <= 1'b0;
            bus_err_MEM    <= 1'b0;
        end else begin
            misaligned_MEM <= misaligned;
            bus_err_MEM    <= timeout;
            if (stall_MEM) begin
                RegWrite_WB <= 1'b0;
            end else begin
                wb_data_WB  <= (MemtoReg_MEM && load_done) ? dmem.dmem_rdata : alu_MEM;
                rd_WB       <= rd_MEM;
                RegWrite_WB <= RegWrite_MEM & ~is_store & ~misaligned & ~timeout;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with a delay-programmable memory model
module tb_mem_access_stage;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_MEM = 32'd0;
    logic [31:0] rs2_mem_data_MEM = 32'd0;
    logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0, RegWrite_MEM = 1'b0, MemtoReg_MEM = 1'b0;
    logic [4:0]  rd_MEM = 5'd0;
    logic        stall_MEM;
    logic [31:0] wb_data_WB;
    logic [4:0]  rd_WB;
    logic        RegWrite_WB, misaligned_MEM, bus_err_MEM;

    mem_access_stage_if dmem_bus();

    mem_access_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .alu_MEM(alu_MEM), .rs2_mem_data_MEM(rs2_mem_data_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .rd_MEM(rd_MEM), .dmem(dmem_bus), .stall_MEM(stall_MEM),
        .wb_data_WB(wb_data_WB), .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB),
        .misaligned_MEM(misaligned_MEM), .bus_err_MEM(bus_err_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rd_en, wr_en, rw, m2r;
        logic [31:0] alu, wdat, rdata;
        logic [4:0] rd;
        int rdy_dly, rv_dly;
        bit nrdy, nrv;
    } instr_t;

    typedef struct {
        int stalls, reqs, hs, field_bad, bubble_bad;
        bit timed_out;
        logic hs_we;
        logic [31:0] hs_addr, hs_wdata;
    } obs_t;

    typedef struct {
        int stalls, reqs, hs;
        logic rw, mis, berr;
        logic [31:0] data;
    } exp_t;

    int n_cmp = 0, n_bad = 0;

    // memory model configuration (written by the stimulus side only)
    int rdy_dly = 0, rv_dly = 0;
    bit never_rdy = 0, never_rv = 0, inject_rv = 0;
    logic [31:0] rsp_data = 32'd0;

    // memory model state (written by the responder only)
    int hs_count = 0, req_cnt = 0, wait_cnt = 0;
    bit pend = 0;
    logic hs_we = 1'b0;
    logic [31:0] hs_addr = 32'd0, hs_wdata = 32'd0;

    initial begin
        dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            dmem_bus.dmem_ready = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = $urandom;
            if (!rst) begin
                req_cnt = 0; pend = 0;
            end else begin
                if (inject_rv) begin
                    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = rsp_data;
                end else if (pend) begin
                    wait_cnt++;
                    if (!never_rv && wait_cnt > rv_dly) begin
                        dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = rsp_data; pend = 0;
                    end
                end
                if (dmem_bus.dmem_req) begin
                    req_cnt++;
                    if (!never_rdy && req_cnt > rdy_dly) begin
                        dmem_bus.dmem_ready = 1'b1; hs_count++;
                        hs_we = dmem_bus.dmem_we; hs_addr = dmem_bus.dmem_addr; hs_wdata = dmem_bus.dmem_wdata;
                        req_cnt = 0; pend = !dmem_bus.dmem_we; wait_cnt = 0;
                    end
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t mk(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                                  input logic [31:0] alu, input logic [31:0] wdat, input logic [4:0] rd,
                                  input int rdy, input int rv, input bit nrdy, input bit nrv,
                                  input logic [31:0] rdata);
        instr_t i;
        i.rd_en = rd_en; i.wr_en = wr_en; i.rw = rw; i.m2r = m2r; i.alu = alu; i.wdat = wdat;
        i.rd = rd; i.rdy_dly = rdy; i.rv_dly = rv; i.nrdy = nrdy; i.nrv = nrv; i.rdata = rdata;
        return i;
    endfunction

    // Reference: latency 1+N (store) or 1+N+M (load) with the whole access bounded by T cycles.
    function automatic exp_t model(input instr_t in);
        exp_t e;
        int n, m;
        logic mem, st;
        mem = in.rd_en | in.wr_en;
        st  = in.wr_en;
        n = in.rdy_dly + 1;
        m = in.rv_dly + 1;
        e.stalls = 0; e.reqs = 0; e.hs = 0; e.berr = 1'b0;
        e.mis = mem && (in.alu[1:0] != 2'b00);
        if (mem && !e.mis) begin
            if (in.nrdy || n > T) begin
                e.stalls = T; e.reqs = T; e.berr = 1'b1;
            end else if (st) begin
                e.stalls = n; e.reqs = n; e.hs = 1;
            end else begin
                e.reqs = n; e.hs = 1;
                if (in.nrv || n + m > T) begin e.stalls = T; e.berr = 1'b1; end
                else e.stalls = n + m;
            end
        end
        e.rw   = in.rw & ~st & ~e.mis & ~e.berr;
        e.data = (in.m2r && in.rd_en && !st) ? in.rdata : in.alu;
        return e;
    endfunction

    // Drives one EX/MEM instruction and holds it until the stage stops stalling; ends at posedge+1.
    task automatic issue(input instr_t in, output obs_t o);
        int hs0;
        logic [31:0] pwb;
        logic [4:0] prd;
        bit done;
        alu_MEM = in.alu; rs2_mem_data_MEM = in.wdat; MemRead_MEM = in.rd_en; MemWrite_MEM = in.wr_en;
        RegWrite_MEM = in.rw; MemtoReg_MEM = in.m2r; rd_MEM = in.rd;
        rdy_dly = in.rdy_dly; rv_dly = in.rv_dly; never_rdy = in.nrdy; never_rv = in.nrv; rsp_data = in.rdata;
        o.stalls = 0; o.reqs = 0; o.field_bad = 0; o.bubble_bad = 0;
        hs0 = hs_count; pwb = wb_data_WB; prd = rd_WB; done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk); #1;
            if (dmem_bus.dmem_req === 1'b1) begin
                o.reqs++;
                if (dmem_bus.dmem_addr !== in.alu || dmem_bus.dmem_we !== in.wr_en ||
                    (in.wr_en && dmem_bus.dmem_wdata !== in.wdat)) o.field_bad++;
            end else if (dmem_bus.dmem_we !== 1'b0) begin
                o.field_bad++;
            end
            if (stall_MEM === 1'b0) begin
                done = 1;
            end else begin
                o.stalls++;
                @(posedge clk); #1;
                if (RegWrite_WB !== 1'b0 || misaligned_MEM !== 1'b0 || bus_err_MEM !== 1'b0 ||
                    rd_WB !== prd || wb_data_WB !== pwb) o.bubble_bad++;
            end
        end
        o.timed_out = !done;
        @(posedge clk); #1;
        o.hs = hs_count - hs0; o.hs_we = hs_we; o.hs_addr = hs_addr; o.hs_wdata = hs_wdata;
    endtask

    task automatic test_reset();
        MemRead_MEM = 1'b1; alu_MEM = 32'h100; RegWrite_MEM = 1'b1; rd_MEM = 5'd3;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({stall_MEM, dmem_bus.dmem_req, dmem_bus.dmem_we} !== 3'b000) begin n_bad++; $display("FAIL reset_async_ctrl got %b exp 000", {stall_MEM, dmem_bus.dmem_req, dmem_bus.dmem_we}); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({stall_MEM, dmem_bus.dmem_req, dmem_bus.dmem_we, RegWrite_WB, misaligned_MEM, bus_err_MEM} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b exp 000000", {stall_MEM, dmem_bus.dmem_req, dmem_bus.dmem_we, RegWrite_WB, misaligned_MEM, bus_err_MEM}); end
        n_cmp++; if (wb_data_WB !== 32'd0) begin n_bad++; $display("FAIL reset_wb_data got %h exp 0", wb_data_WB); end
        n_cmp++; if (rd_WB !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d exp 0", rd_WB); end
        MemRead_MEM = 1'b0; RegWrite_MEM = 1'b0; rd_MEM = 5'd0; alu_MEM = 32'd0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        obs_t o;
        issue(mk(0, 0, 1, 0, 32'h10, 32'h0, 5'd5, 0, 0, 0, 0, 32'h0), o);
        n_cmp++; if (o.stalls != 0) begin n_bad++; $display("FAIL alu_stall got %0d exp 0", o.stalls); end
        n_cmp++; if (wb_data_WB !== 32'h10) begin n_bad++; $display("FAIL alu_wb_data got %h exp 00000010", wb_data_WB); end
        n_cmp++; if (rd_WB !== 5'd5 || RegWrite_WB !== 1'b1) begin n_bad++; $display("FAIL alu_rd_we got rd=%0d we=%b exp rd=5 we=1", rd_WB, RegWrite_WB); end
        n_cmp++; if (o.reqs != 0 || o.hs != 0) begin n_bad++; $display("FAIL alu_no_req got reqs=%0d hs=%0d exp 0", o.reqs, o.hs); end
    endtask

    task automatic test_load();
        obs_t o;
        issue(mk(1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 2, 0, 0, 0, 32'hDEADBEEF), o);
        n_cmp++; if (o.stalls != 4) begin n_bad++; $display("FAIL load_stall got %0d exp 4", o.stalls); end
        n_cmp++; if (wb_data_WB !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_wb_data got %h exp deadbeef", wb_data_WB); end
        n_cmp++; if (rd_WB !== 5'd7 || RegWrite_WB !== 1'b1) begin n_bad++; $display("FAIL load_rd_we got rd=%0d we=%b exp rd=7 we=1", rd_WB, RegWrite_WB); end
        n_cmp++; if (o.hs != 1 || o.hs_we !== 1'b0 || o.hs_addr !== 32'h100) begin n_bad++; $display("FAIL load_handshake got hs=%0d we=%b addr=%h exp 1 0 00000100", o.hs, o.hs_we, o.hs_addr); end
        n_cmp++; if (o.field_bad != 0 || o.bubble_bad != 0) begin n_bad++; $display("FAIL load_stability got field=%0d bubble=%0d exp 0", o.field_bad, o.bubble_bad); end
    endtask

    task automatic test_store();
        obs_t o;
        issue(mk(0, 1, 1, 0, 32'h20, 32'h1234, 5'd4, 0, 0, 0, 0, 32'h0), o);
        n_cmp++; if (o.stalls != 1) begin n_bad++; $display("FAIL store_stall got %0d exp 1", o.stalls); end
        n_cmp++; if (o.reqs != 1 || o.hs != 1) begin n_bad++; $display("FAIL store_req got reqs=%0d hs=%0d exp 1 1", o.reqs, o.hs); end
        n_cmp++; if (o.hs_we !== 1'b1 || o.hs_addr !== 32'h20 || o.hs_wdata !== 32'h1234) begin n_bad++; $display("FAIL store_fields got we=%b addr=%h wdata=%h exp 1 00000020 00001234", o.hs_we, o.hs_addr, o.hs_wdata); end
        n_cmp++; if (RegWrite_WB !== 1'b0) begin n_bad++; $display("FAIL store_regwrite got %b exp 0", RegWrite_WB); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        issue(mk(1, 0, 1, 1, 32'h103, 32'h0, 5'd8, 0, 0, 0, 0, 32'h55), o);
        n_cmp++; if (o.reqs != 0 || o.stalls != 0) begin n_bad++; $display("FAIL misaligned_noreq got reqs=%0d stalls=%0d exp 0 0", o.reqs, o.stalls); end
        n_cmp++; if (misaligned_MEM !== 1'b1 || RegWrite_WB !== 1'b0) begin n_bad++; $display("FAIL misaligned_pulse got mis=%b we=%b exp 1 0", misaligned_MEM, RegWrite_WB); end
        issue(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0), o);
        n_cmp++; if (misaligned_MEM !== 1'b0) begin n_bad++; $display("FAIL misaligned_clear got %b exp 0", misaligned_MEM); end
    endtask

    task automatic test_timeout();
        obs_t o;
        issue(mk(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 0, 0, 1, 0, 32'h0), o);
        n_cmp++; if (o.reqs != T || o.stalls != T) begin n_bad++; $display("FAIL tmo_req_cycles got reqs=%0d stalls=%0d exp %0d", o.reqs, o.stalls, T); end
        n_cmp++; if (bus_err_MEM !== 1'b1 || RegWrite_WB !== 1'b0 || o.hs != 0) begin n_bad++; $display("FAIL tmo_buserr got err=%b we=%b hs=%0d exp 1 0 0", bus_err_MEM, RegWrite_WB, o.hs); end
        issue(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0), o);
        n_cmp++; if (bus_err_MEM !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got %b exp 0", bus_err_MEM); end
        issue(mk(1, 0, 1, 1, 32'h44, 32'h0, 5'd10, 2, 0, 0, 1, 32'h0), o);
        n_cmp++; if (o.stalls != T || o.hs != 1 || bus_err_MEM !== 1'b1 || RegWrite_WB !== 1'b0) begin n_bad++; $display("FAIL tmo_wait got stalls=%0d hs=%0d err=%b we=%b exp %0d 1 1 0", o.stalls, o.hs, bus_err_MEM, RegWrite_WB, T); end
    endtask

    task automatic test_reset_mid_access();
        int hs0;
        bit seen;
        alu_MEM = 32'h200; MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; RegWrite_MEM = 1'b1; MemtoReg_MEM = 1'b1; rd_MEM = 5'd9;
        rdy_dly = 0; never_rdy = 0; never_rv = 1;
        hs0 = hs_count; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (hs_count != hs0) seen = 1;
        end
        n_cmp++; if (!seen || stall_MEM !== 1'b1) begin n_bad++; $display("FAIL midrst_wait got seen=%0d stall=%b exp 1 1", seen, stall_MEM); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({stall_MEM, dmem_bus.dmem_req, RegWrite_WB, misaligned_MEM, bus_err_MEM} !== 5'b0 || wb_data_WB !== 32'd0 || rd_WB !== 5'd0) begin n_bad++; $display("FAIL midrst_async got ctrl=%b wb=%h rd=%0d exp 0", {stall_MEM, dmem_bus.dmem_req, RegWrite_WB, misaligned_MEM, bus_err_MEM}, wb_data_WB, rd_WB); end
        alu_MEM = 32'h0; MemRead_MEM = 1'b0; RegWrite_MEM = 1'b0; MemtoReg_MEM = 1'b1; rd_MEM = 5'd0;
        @(negedge clk); #1;
        rst = 1'b1; inject_rv = 1; rsp_data = 32'hCAFEF00D;
        @(negedge clk); #1;
        n_cmp++; if (stall_MEM !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_late_rv got stall=%b req=%b exp 0 0", stall_MEM, dmem_bus.dmem_req); end
        inject_rv = 0;
        @(posedge clk); #1;
        n_cmp++; if (wb_data_WB !== 32'd0 || RegWrite_WB !== 1'b0 || rd_WB !== 5'd0) begin n_bad++; $display("FAIL midrst_no_wb got wb=%h we=%b rd=%0d exp 0 0 0", wb_data_WB, RegWrite_WB, rd_WB); end
        never_rv = 0; MemtoReg_MEM = 1'b0;
    endtask

    task automatic test_random_stream();
        instr_t in;
        obs_t o;
        exp_t e;
        int kind;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            a = $urandom;
            a[1:0] = 2'b00;
            in = mk(0, 0, 1'($urandom_range(0, 1)), 0, a, $urandom, 5'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 0, 0, $urandom);
            case (kind)
                1, 2: begin in.rd_en = 1; in.m2r = 1; end
                3:    begin in.wr_en = 1; in.rd_en = 1'($urandom_range(0, 1)); end
                4:    begin in.rd_en = 1'($urandom_range(0, 1)); in.wr_en = ~in.rd_en; in.alu[1:0] = 2'($urandom_range(1, 3)); end
                5:    begin in.rd_en = 1; in.m2r = 1; in.wr_en = 1'($urandom_range(0, 1));
                            if ($urandom_range(0, 1) == 1) in.nrdy = 1; else in.nrv = 1; end
                default: ;
            endcase
            e = model(in);
            issue(in, o);
            n_cmp++; if (o.timed_out || o.stalls != e.stalls) begin n_bad++; $display("FAIL rnd%0d_stall got %0d (hung=%0d) exp %0d", i, o.stalls, o.timed_out, e.stalls); end
            n_cmp++; if (o.reqs != e.reqs || o.hs != e.hs) begin n_bad++; $display("FAIL rnd%0d_req got reqs=%0d hs=%0d exp %0d %0d", i, o.reqs, o.hs, e.reqs, e.hs); end
            n_cmp++; if (o.field_bad != 0 || o.bubble_bad != 0) begin n_bad++; $display("FAIL rnd%0d_stable got field=%0d bubble=%0d exp 0 0", i, o.field_bad, o.bubble_bad); end
            n_cmp++; if (RegWrite_WB !== e.rw || rd_WB !== in.rd) begin n_bad++; $display("FAIL rnd%0d_wb_ctl got we=%b rd=%0d exp %b %0d", i, RegWrite_WB, rd_WB, e.rw, in.rd); end
            if (e.rw) begin
                n_cmp++; if (wb_data_WB !== e.data) begin n_bad++; $display("FAIL rnd%0d_wb_data got %h exp %h", i, wb_data_WB, e.data); end
            end
            n_cmp++; if (misaligned_MEM !== e.mis || bus_err_MEM !== e.berr) begin n_bad++; $display("FAIL rnd%0d_faults got mis=%b err=%b exp %b %b", i, misaligned_MEM, bus_err_MEM, e.mis, e.berr); end
            if (e.hs == 1) begin
                n_cmp++; if (o.hs_addr !== in.alu || o.hs_we !== in.wr_en) begin n_bad++; $display("FAIL rnd%0d_hs got addr=%h we=%b exp %h %b", i, o.hs_addr, o.hs_we, in.alu, in.wr_en); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
